// File: rtl/sparse_cluster_compactor.sv
// ============================================================================
// Module      : sparse_cluster_compactor
// Description : Compacts mask-selected clusters into a shift buffer and emits
//               dense MAC groups; optional SPARSE_COMPACTOR_COUNT_EN adds a
//               saturating accepted-cluster counter port (clusterCount).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sparse_cluster_compactor #(
    parameter int NUM_CLUSTERS_IN  = 4,
    parameter int CLUSTER_WIDTH    = 16,
    parameter int NUM_CLUSTERS_OUT = 2,
    parameter int BUFFER_DEPTH     = 8,
    parameter int OCC_BITWIDTH     = 4
) (
    input  logic                                         clock,
    input  logic                                         reset,
    input  logic                                         ivalid,
    output logic                                         oready,
    input  logic [NUM_CLUSTERS_IN-1:0]                   inputBitmask,
    input  logic [NUM_CLUSTERS_IN*CLUSTER_WIDTH-1:0]     inputBlock,
    input  logic                                         inputLast,
    output logic                                         ovalid,
    input  logic                                         iready,
    output logic [NUM_CLUSTERS_OUT*CLUSTER_WIDTH-1:0]    macClusters,
    output logic [NUM_CLUSTERS_OUT-1:0]                  macMask,
    output logic                                         macLast
`ifdef SPARSE_COMPACTOR_COUNT_EN
    ,output logic [31:0]                                 clusterCount
`endif
);

    localparam int c_BIDX_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
    localparam int c_CIDX_W = (NUM_CLUSTERS_IN > 1) ? $clog2(NUM_CLUSTERS_IN) : 1;

    typedef enum logic [0:0] {
        S_FILL  = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    state_t                         r_state, w_state_nxt;
    logic [CLUSTER_WIDTH-1:0]       r_buf     [BUFFER_DEPTH];
    logic [CLUSTER_WIDTH-1:0]       w_buf_nxt [BUFFER_DEPTH];
    logic [CLUSTER_WIDTH-1:0]       w_cmp     [NUM_CLUSTERS_IN];
    logic [OCC_BITWIDTH-1:0]        r_occ, w_occ_nxt, w_push, w_pop;
    logic [NUM_CLUSTERS_OUT*CLUSTER_WIDTH-1:0] w_grp_clusters;
    logic [NUM_CLUSTERS_OUT-1:0]    w_grp_mask;
    logic                           w_accept, w_can_load, w_load_data, w_load_empty, w_group_last;
    int                             w_sel_cnt;
    int                             w_keep;

    assign w_accept     = ivalid & oready;
    assign w_can_load   = !ovalid || iready;
    assign w_load_data  = w_can_load &&
                          ((r_occ >= OCC_BITWIDTH'(NUM_CLUSTERS_OUT)) ||
                           (r_state == S_FLUSH && r_occ != '0));
    assign w_load_empty = w_can_load && (r_state == S_FLUSH) && (r_occ == '0);
    assign w_pop        = !w_load_data ? '0 :
                          (r_occ >= OCC_BITWIDTH'(NUM_CLUSTERS_OUT)) ? OCC_BITWIDTH'(NUM_CLUSTERS_OUT) : r_occ;
    assign w_group_last = (r_state == S_FLUSH) && (r_occ <= OCC_BITWIDTH'(NUM_CLUSTERS_OUT));
    assign w_occ_nxt    = r_occ - w_pop + w_push;

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_FILL;
        else       r_state <= w_state_nxt;
    end

    // oready is held low during reset so nothing is accepted before state is known
    always_comb begin
        w_state_nxt = r_state;
        oready      = 1'b0;
        case (r_state)
            S_FILL: begin
                oready = !reset && ((BUFFER_DEPTH - int'(r_occ)) >= NUM_CLUSTERS_IN);
                if (ivalid && oready && inputLast) w_state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                if ((w_load_data && w_group_last) || w_load_empty) w_state_nxt = S_FILL;
            end
            default: w_state_nxt = S_FILL;
        endcase
    end

    always_comb begin
        w_sel_cnt = 0;
        for (int i = 0; i < NUM_CLUSTERS_IN; i++) w_cmp[i] = '0;
        for (int i = 0; i < NUM_CLUSTERS_IN; i++) begin
            if (inputBitmask[i]) begin
                w_cmp[c_CIDX_W'(w_sel_cnt)] = inputBlock[i*CLUSTER_WIDTH +: CLUSTER_WIDTH];
                w_sel_cnt = w_sel_cnt + 1;
            end
        end
        w_push = w_accept ? OCC_BITWIDTH'(w_sel_cnt) : '0;
    end

    // Survivors shift down by the pop count; pushed clusters land right behind them
    always_comb begin
        w_keep = int'(r_occ) - int'(w_pop);
        for (int j = 0; j < BUFFER_DEPTH; j++) begin
            w_buf_nxt[j] = r_buf[j];
            if (j < w_keep)
                w_buf_nxt[j] = r_buf[c_BIDX_W'(j + int'(w_pop))];
            else if ((j - w_keep) < int'(w_push))
                w_buf_nxt[j] = w_cmp[c_CIDX_W'(j - w_keep)];
        end
    end

    always_comb begin
        w_grp_clusters = '0;
        w_grp_mask     = '0;
        for (int k = 0; k < NUM_CLUSTERS_OUT; k++) begin
            if (OCC_BITWIDTH'(k) < w_pop) begin
                w_grp_clusters[k*CLUSTER_WIDTH +: CLUSTER_WIDTH] = r_buf[c_BIDX_W'(k)];
                w_grp_mask[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int j = 0; j < BUFFER_DEPTH; j++) r_buf[j] <= w_buf_nxt[j];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_occ       <= '0;
            ovalid      <= 1'b0;
            macClusters <= '0;
            macMask     <= '0;
            macLast     <= 1'b0;
        end else begin
            r_occ <= w_occ_nxt;
            if (w_load_data) begin
                ovalid      <= 1'b1;
                macClusters <= w_grp_clusters;
                macMask     <= w_grp_mask;
                macLast     <= w_group_last;
            end else if (w_load_empty) begin
                ovalid      <= 1'b1;
                macClusters <= '0;
                macMask     <= '0;
                macLast     <= 1'b1;
            end else if (iready) begin
                ovalid      <= 1'b0;
            end
        end
    end

`ifdef SPARSE_COMPACTOR_COUNT_EN
    logic [31:0] r_cluster_count;
    logic [32:0] w_cnt_sum;

    assign w_cnt_sum    = {1'b0, r_cluster_count} + {{(33-OCC_BITWIDTH){1'b0}}, w_push};
    assign clusterCount = r_cluster_count;

    always_ff @(posedge clock) begin
        if (reset)         r_cluster_count <= '0;
        else if (w_accept) r_cluster_count <= w_cnt_sum[32] ? '1 : w_cnt_sum[31:0];
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_sparse_cluster_compactor.sv
// ============================================================================
// Module      : tb_sparse_cluster_compactor
// Description : Directed self-checking bench for sparse_cluster_compactor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sparse_cluster_compactor;

    logic        clock = 1'b0;
    logic        reset;
    logic        ivalid;
    logic        oready;
    logic [3:0]  inputBitmask;
    logic [63:0] inputBlock;
    logic        inputLast;
    logic        ovalid;
    logic        iready;
    logic [31:0] macClusters;
    logic [1:0]  macMask;
    logic        macLast;
`ifdef SPARSE_COMPACTOR_COUNT_EN
    logic [31:0] clusterCount;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    sparse_cluster_compactor dut (
        .clock        (clock),
        .reset        (reset),
        .ivalid       (ivalid),
        .oready       (oready),
        .inputBitmask (inputBitmask),
        .inputBlock   (inputBlock),
        .inputLast    (inputLast),
        .ovalid       (ovalid),
        .iready       (iready),
        .macClusters  (macClusters),
        .macMask      (macMask),
        .macLast      (macLast)
`ifdef SPARSE_COMPACTOR_COUNT_EN
        ,.clusterCount(clusterCount)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int blk;
        int idx;
        logic acc;
        logic [15:0] e_lo, e_hi;

        reset = 1'b1; ivalid = 1'b0; iready = 1'b1;
        inputBitmask = '0; inputBlock = '0; inputLast = 1'b0;

        // reset held for 3 cycles, outputs all zero
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_ovalid", ovalid, 0);
            chk("rst_oready", oready, 0);
            chk("rst_clusters", macClusters, 0);
            chk("rst_mask", macMask, 0);
            chk("rst_last", macLast, 0);
        end
        reset = 1'b0;
        #1;
        chk("rel_oready", oready, 1);

        // compaction: mask 1010 picks clusters 1 and 3
        ivalid = 1'b1; inputBitmask = 4'b1010; inputLast = 1'b0;
        inputBlock = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
        tick();
        ivalid = 1'b0;
        chk("cmp_nogrp_yet", ovalid, 0);
        tick();
        chk("cmp_ovalid", ovalid, 1);
        chk("cmp_clusters", macClusters, 32'h0004_0002);
        chk("cmp_mask", macMask, 2'b11);
        chk("cmp_last", macLast, 0);
        chk("cmp_occ", dut.r_occ, 0);

        // partial flush with a single selected cluster
        ivalid = 1'b1; inputBitmask = 4'b0001; inputLast = 1'b1;
        inputBlock = {48'h0, 16'h00AA};
        tick();
        ivalid = 1'b0; inputLast = 1'b0;
        chk("pf_oready_flush", oready, 0);
        tick();
        chk("pf_ovalid", ovalid, 1);
        chk("pf_clusters", macClusters, 32'h0000_00AA);
        chk("pf_mask", macMask, 2'b01);
        chk("pf_last", macLast, 1);
        chk("pf_oready_after", oready, 1);
        tick();
        chk("pf_ovalid_clear", ovalid, 0);

        // backpressure: 4 full blocks holding 0x0001..0x0010
        iready = 1'b0; blk = 0;
        for (int c = 0; c < 6; c++) begin
            ivalid = (blk < 4);
            inputBitmask = 4'b1111;
            inputBlock = {16'(4*blk+4), 16'(4*blk+3), 16'(4*blk+2), 16'(4*blk+1)};
            acc = ivalid && oready;
            tick();
            if (acc) blk++;
            if (c == 3) chk("bp_stall_mid", macClusters, 32'h0002_0001);
        end
        chk("bp_blocks_taken", blk, 2);
        chk("bp_oready_low", oready, 0);
        chk("bp_ovalid_held", ovalid, 1);
        chk("bp_stall_grp", macClusters, 32'h0002_0001);
        chk("bp_stall_mask", macMask, 2'b11);

        iready = 1'b1; idx = 0;
        for (int c = 0; c < 40 && idx < 8; c++) begin
            if (ovalid) begin
                e_lo = 16'(2*idx+1);
                e_hi = 16'(2*idx+2);
                chk($sformatf("bp_grp%0d", idx), {macMask, macClusters}, {2'b11, e_hi, e_lo});
                idx++;
            end
            ivalid = (blk < 4);
            inputBlock = {16'(4*blk+4), 16'(4*blk+3), 16'(4*blk+2), 16'(4*blk+1)};
            acc = ivalid && oready;
            tick();
            if (acc) blk++;
        end
        ivalid = 1'b0;
        chk("bp_group_count", idx, 8);
        chk("bp_no_extra", ovalid, 0);
        chk("bp_occ_empty", dut.r_occ, 0);

        // empty last block
        ivalid = 1'b1; inputBitmask = 4'b0000; inputLast = 1'b1;
        tick();
        ivalid = 1'b0; inputLast = 1'b0;
        chk("el_oready_flush", oready, 0);
        tick();
        chk("el_ovalid", ovalid, 1);
        chk("el_mask", macMask, 0);
        chk("el_clusters", macClusters, 0);
        chk("el_last", macLast, 1);
        chk("el_oready_fill", oready, 1);
        tick();
        chk("el_single", ovalid, 0);

        // reset while a full last block sits in the buffer
        ivalid = 1'b1; inputBitmask = 4'b1111; inputLast = 1'b1;
        inputBlock = {16'h00D4, 16'h00D3, 16'h00D2, 16'h00D1};
        tick();
        ivalid = 1'b0; inputLast = 1'b0;
`ifdef SPARSE_COMPACTOR_COUNT_EN
        chk("cnt_total", clusterCount, 23);
`endif
        reset = 1'b1;
        tick();
        chk("rmf_ovalid", ovalid, 0);
        chk("rmf_last", macLast, 0);
        chk("rmf_oready_rst", oready, 0);
        reset = 1'b0;
        #1;
        chk("rmf_oready", oready, 1);
        chk("rmf_occ", dut.r_occ, 0);
        chk("rmf_state", dut.r_state, 0);
`ifdef SPARSE_COMPACTOR_COUNT_EN
        chk("rmf_count", clusterCount, 0);
`endif
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rmf_quiet", {ovalid, macLast}, 2'b00);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
